// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse direction tracker.
//   dir_idx_t / DIR_* : bit index of each direction in the 9-bit one-hot (row*3+col)
//   trk_state_t       : tracker FSM states
//   dir_onehot()      : turns a (row, col) classification into the one-hot direction
package mouse_pkg;

  typedef logic [3:0] dir_idx_t;

  localparam dir_idx_t DIR_UL = 4'd0;
  localparam dir_idx_t DIR_U  = 4'd1;
  localparam dir_idx_t DIR_UR = 4'd2;
  localparam dir_idx_t DIR_L  = 4'd3;
  localparam dir_idx_t DIR_C  = 4'd4;
  localparam dir_idx_t DIR_R  = 4'd5;
  localparam dir_idx_t DIR_DL = 4'd6;
  localparam dir_idx_t DIR_D  = 4'd7;
  localparam dir_idx_t DIR_DR = 4'd8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACK = 2'd1,
    IDLE  = 2'd2
  } trk_state_t;

  // row/col are 0..2; 0 = up/left, 1 = centre, 2 = down/right.
  function automatic logic [8:0] dir_onehot(input logic [1:0] row, input logic [1:0] col);
    logic [8:0] oh;
    dir_idx_t   idx;
    oh       = '0;
    idx      = 4'(row) * 4'd3 + 4'(col);
    oh[idx]  = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mouse_hist_ring.sv
// History ring for the mouse tracker.
//   PS2_CLK, reset : clock and synchronous active-high reset
//   flush          : clears the write pointer only; contents are left as don't-care
//   wr_en          : write x_wr/y_wr at the pointer and advance it
//   x_old, y_old   : combinational read of the slot about to be overwritten (oldest entry)
module mouse_hist_ring
  import mouse_pkg::*;
#(
  parameter int unsigned XW    = 11,
  parameter int unsigned YW    = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic          PS2_CLK,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [XW-1:0] x_wr,
  input  logic [YW-1:0] y_wr,
  output logic [XW-1:0] x_old,
  output logic [YW-1:0] y_old
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XW-1:0] x_mem [DEPTH];
  logic [YW-1:0] y_mem [DEPTH];
  logic [PW-1:0] wptr_q;

  // DEPTH is a power of two, so the pointer wraps by natural overflow.
  always_ff @(posedge PS2_CLK) begin
    if (reset || flush) begin
      wptr_q <= '0;
    end else if (wr_en) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge PS2_CLK) begin
    if (wr_en) begin
      x_mem[wptr_q] <= x_wr;
      y_mem[wptr_q] <= y_wr;
    end
  end

  assign x_old = x_mem[wptr_q];
  assign y_old = y_mem[wptr_q];

endmodule

// File: rtl/mouse_dir_tracker.sv
// Mouse direction tracker: compares each new binned position with the oldest of a
// DEPTH-deep history and classifies the displacement into a one-hot 3x3 direction.
//   PS2_CLK, reset      : clock and synchronous active-high reset
//   sample_valid        : x_in/y_in carry a new position
//   flush               : clear history and return to warm-up (wins over sample_valid)
//   ms_dir              : one-hot direction, index row*3+col, centre = 9'h010
//   dx, dy              : signed displacement new minus oldest, XW+1 / YW+1 bits
//   dir_valid           : outputs were computed from a full history
//   idle                : IDLE_CNT consecutive centre classifications
module mouse_dir_tracker
  import mouse_pkg::*;
#(
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 11,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DEAD     = 1,
  parameter int unsigned IDLE_CNT = 16
) (
  input  logic        PS2_CLK,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic        flush,
  output logic [8:0]  ms_dir,
  output logic [XW:0] dx,
  output logic [YW:0] dy,
  output logic        dir_valid,
  output logic        idle
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned ICW = $clog2(IDLE_CNT + 1);

  localparam logic [PW-1:0]  FILL_LAST = PW'(DEPTH - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CNT - 1);
  localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_CNT);

  localparam logic signed [XW:0] DEAD_X = (XW + 1)'(DEAD);
  localparam logic signed [YW:0] DEAD_Y = (YW + 1)'(DEAD);

  localparam logic [8:0] CENTRE = 9'h010;

  logic [XW-1:0] x_old;
  logic [YW-1:0] y_old;
  logic          wr_en;

  // A flushed sample is dropped, so it must not reach the history either.
  assign wr_en = sample_valid && !flush;

  mouse_hist_ring #(
    .XW    (XW),
    .YW    (YW),
    .DEPTH (DEPTH)
  ) u_hist (
    .PS2_CLK (PS2_CLK),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (wr_en),
    .x_wr    (x_in),
    .y_wr    (y_in),
    .x_old   (x_old),
    .y_old   (y_old)
  );

  // Zero-extend before subtracting so full-scale jumps never wrap.
  logic signed [XW:0] dx_calc;
  logic signed [YW:0] dy_calc;
  logic [1:0]         col, row;
  logic [8:0]         dir_calc;
  logic               centre;

  always_comb begin
    dx_calc = $signed({1'b0, x_in} - {1'b0, x_old});
    dy_calc = $signed({1'b0, y_in} - {1'b0, y_old});
    if (dx_calc < -DEAD_X)     col = 2'd0;
    else if (dx_calc > DEAD_X) col = 2'd2;
    else                       col = 2'd1;
    if (dy_calc < -DEAD_Y)     row = 2'd0;
    else if (dy_calc > DEAD_Y) row = 2'd2;
    else                       row = 2'd1;
    dir_calc = dir_onehot(row, col);
    centre   = (row == 2'd1) && (col == 2'd1);
  end

  trk_state_t     state_q, state_d;
  logic [PW-1:0]  fill_q, fill_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic [8:0]     ms_dir_q, ms_dir_d;
  logic [XW:0]    dx_q, dx_d;
  logic [YW:0]    dy_q, dy_d;
  logic           valid_q, valid_d;
  logic           idle_q, idle_d;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    icnt_d   = icnt_q;
    ms_dir_d = ms_dir_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    valid_d  = valid_q;
    idle_d   = idle_q;
    if (flush) begin
      state_d  = FILL;
      fill_d   = '0;
      icnt_d   = '0;
      ms_dir_d = CENTRE;
      dx_d     = '0;
      dy_d     = '0;
      valid_d  = 1'b0;
      idle_d   = 1'b0;
    end else if (sample_valid) begin
      unique case (state_q)
        FILL: begin
          if (fill_q == FILL_LAST) begin
            state_d = TRACK;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        TRACK, IDLE: begin
          ms_dir_d = dir_calc;
          dx_d     = dx_calc;
          dy_d     = dy_calc;
          valid_d  = 1'b1;
          if (!centre) begin
            state_d = TRACK;
            icnt_d  = '0;
            idle_d  = 1'b0;
          end else if (state_q == TRACK) begin
            if (icnt_q == IDLE_LAST) begin
              state_d = IDLE;
              icnt_d  = IDLE_MAX;
              idle_d  = 1'b1;
            end else begin
              icnt_d = icnt_q + 1'b1;
            end
          end
          // In IDLE a centre result leaves the saturated count alone.
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge PS2_CLK) begin
    if (reset) begin
      state_q  <= FILL;
      fill_q   <= '0;
      icnt_q   <= '0;
      ms_dir_q <= CENTRE;
      dx_q     <= '0;
      dy_q     <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      icnt_q   <= icnt_d;
      ms_dir_q <= ms_dir_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
    end
  end

  assign ms_dir    = ms_dir_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign dir_valid = valid_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_mouse_dir_tracker.sv
module tb_mouse_dir_tracker;

  logic        PS2_CLK = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [10:0] x_in = '0;
  logic [10:0] y_in = '0;
  logic        flush = 1'b0;
  logic [8:0]  ms_dir;
  logic [11:0] dx;
  logic [11:0] dy;
  logic        dir_valid;
  logic        idle;

  int checks = 0;
  int errors = 0;

  mouse_dir_tracker #(
    .XW       (11),
    .YW       (11),
    .DEPTH    (4),
    .DEAD     (1),
    .IDLE_CNT (16)
  ) dut (
    .PS2_CLK      (PS2_CLK),
    .reset        (reset),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .flush        (flush),
    .ms_dir       (ms_dir),
    .dx           (dx),
    .dy           (dy),
    .dir_valid    (dir_valid),
    .idle         (idle)
  );

  always #5 PS2_CLK = ~PS2_CLK;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic sample(input int x, input int y);
    @(negedge PS2_CLK);
    sample_valid = 1'b1;
    x_in = 11'(x);
    y_in = 11'(y);
    @(negedge PS2_CLK);
    sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge PS2_CLK);
    flush = 1'b1;
    @(negedge PS2_CLK);
    flush = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [8:0] e_dir, input int e_dx,
                         input int e_dy, input logic e_valid, input logic e_idle);
    logic [11:0] edx, edy;
    edx = 12'(e_dx);
    edy = 12'(e_dy);
    chk({tag, ".ms_dir"}, 16'(ms_dir), 16'(e_dir));
    chk({tag, ".dx"}, 16'(dx), 16'(edx));
    chk({tag, ".dy"}, 16'(dy), 16'(edy));
    chk({tag, ".dir_valid"}, 16'(dir_valid), 16'(e_valid));
    chk({tag, ".idle"}, 16'(idle), 16'(e_idle));
  endtask

  initial begin
    // 1. Reset values and hold with no samples.
    repeat (2) @(posedge PS2_CLK);
    @(negedge PS2_CLK);
    reset = 1'b0;
    chk_out("reset", 9'h010, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge PS2_CLK);
    chk_out("reset_hold", 9'h010, 0, 0, 1'b0, 1'b0);

    // 2. Warm-up then first tracked sample.
    for (int i = 1; i <= 4; i++) begin
      sample(10 * i, 100);
      chk_out("fill", 9'h010, 0, 0, 1'b0, 1'b0);
    end
    sample(50, 100);
    chk_out("first_track", 9'h020, 40, 0, 1'b1, 1'b0);
    repeat (3) @(negedge PS2_CLK);
    chk_out("track_hold", 9'h020, 40, 0, 1'b1, 1'b0);

    // 3. Dead zone, then up-left.
    do_flush();
    chk_out("flush_a", 9'h010, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sample(50, 50);
    sample(51, 49);
    chk_out("dead_zone", 9'h010, 1, -1, 1'b1, 1'b0);
    sample(45, 45);
    chk_out("up_left", 9'h001, -5, -5, 1'b1, 1'b0);

    // 4. Full-scale jumps in both directions.
    do_flush();
    for (int i = 0; i < 4; i++) sample(2047, 2047);
    sample(0, 0);
    chk_out("full_neg", 9'h001, -2047, -2047, 1'b1, 1'b0);
    do_flush();
    for (int i = 0; i < 4; i++) sample(0, 0);
    sample(2047, 2047);
    chk_out("full_pos", 9'h100, 2047, 2047, 1'b1, 1'b0);

    // 5. Idle after exactly 16 centre samples, cleared by motion.
    do_flush();
    for (int i = 0; i < 4; i++) sample(100, 100);
    for (int i = 0; i < 15; i++) begin
      sample(100, 100);
      chk_out("pre_idle", 9'h010, 0, 0, 1'b1, 1'b0);
    end
    sample(100, 100);
    chk_out("idle_on", 9'h010, 0, 0, 1'b1, 1'b1);
    sample(100, 100);
    chk_out("idle_stay", 9'h010, 0, 0, 1'b1, 1'b1);
    sample(103, 100);
    chk_out("idle_off", 9'h020, 3, 0, 1'b1, 1'b0);

    // 6. flush together with sample_valid: flush wins, sample dropped.
    @(negedge PS2_CLK);
    flush = 1'b1;
    sample_valid = 1'b1;
    x_in = 11'd999;
    y_in = 11'd999;
    @(negedge PS2_CLK);
    flush = 1'b0;
    sample_valid = 1'b0;
    chk_out("flush_sv", 9'h010, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample(200 + 10 * i, 50);
      chk_out("refill", 9'h010, 0, 0, 1'b0, 1'b0);
    end
    sample(240, 50);
    chk_out("refill_track", 9'h020, 40, 0, 1'b1, 1'b0);

    // Reset between the 2nd and 3rd fill samples restarts the count.
    do_flush();
    sample(10, 50);
    sample(20, 50);
    @(negedge PS2_CLK);
    reset = 1'b1;
    @(negedge PS2_CLK);
    reset = 1'b0;
    chk_out("mid_reset", 9'h010, 0, 0, 1'b0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      sample(10 * i, 50);
      chk_out("post_reset_fill", 9'h010, 0, 0, 1'b0, 1'b0);
    end
    sample(70, 50);
    chk_out("post_reset_track", 9'h020, 40, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
